// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters (m0 fetch, m1 load/store), the arbiter and the
// single-ported memory. slave = arbiter view, master = requester/memory environment view.
interface memory_arbiter_if;
  logic        m0_req;
  logic [29:0] m0_address;
  logic [31:0] m0_data_in;
  logic [3:0]  m0_data_strobes;
  logic        m0_read;
  logic        m0_write;
  logic        m0_ack;
  logic [31:0] m0_data_out;

  logic        m1_req;
  logic [29:0] m1_address;
  logic [31:0] m1_data_in;
  logic [3:0]  m1_data_strobes;
  logic        m1_read;
  logic        m1_write;
  logic        m1_ack;
  logic [31:0] m1_data_out;

  logic        mem_cs;
  logic [29:0] mem_address;
  logic [31:0] mem_data_out;
  logic [3:0]  mem_data_strobes;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data_in;

  modport slave (
    input  m0_req, m0_address, m0_data_in, m0_data_strobes, m0_read, m0_write,
    output m0_ack, m0_data_out,
    input  m1_req, m1_address, m1_data_in, m1_data_strobes, m1_read, m1_write,
    output m1_ack, m1_data_out,
    output mem_cs, mem_address, mem_data_out, mem_data_strobes, mem_read, mem_write,
    input  mem_data_in
  );

  modport master (
    output m0_req, m0_address, m0_data_in, m0_data_strobes, m0_read, m0_write,
    input  m0_ack, m0_data_out,
    output m1_req, m1_address, m1_data_in, m1_data_strobes, m1_read, m1_write,
    input  m1_ack, m1_data_out,
    input  mem_cs, mem_address, mem_data_out, mem_data_strobes, mem_read, mem_write,
    output mem_data_in
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port arbiter and IDLE/ACCESS/ACK sequencer for the single-ported 512-word memory.
// Every access takes three cycles and ends with a one-cycle ack and registered read data.
module memory_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input logic              clock,
  input logic              reset,
  memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t state;
  logic   grant;       // 0 = m0, 1 = m1
  logic   last_grant;
  logic   pick_m1;

  // Round-robin favours the port that was not served last; a lone requester always wins.
  always_comb begin
    pick_m1 = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      pick_m1 = FIXED_PRIORITY ? 1'b0 : ~last_grant;
    end else begin
      pick_m1 = bus.m1_req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                <= IDLE;
      grant                <= 1'b0;
      last_grant           <= 1'b1;
      bus.mem_cs           <= 1'b0;
      bus.mem_read         <= 1'b0;
      bus.mem_write        <= 1'b0;
      bus.mem_address      <= '0;
      bus.mem_data_out     <= '0;
      bus.mem_data_strobes <= '0;
      bus.m0_ack           <= 1'b0;
      bus.m1_ack           <= 1'b0;
      bus.m0_data_out      <= '0;
      bus.m1_data_out      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            state                <= ACCESS;
            grant                <= pick_m1;
            bus.mem_cs           <= 1'b1;
            bus.mem_address      <= pick_m1 ? bus.m1_address      : bus.m0_address;
            bus.mem_data_out     <= pick_m1 ? bus.m1_data_in      : bus.m0_data_in;
            bus.mem_data_strobes <= pick_m1 ? bus.m1_data_strobes : bus.m0_data_strobes;
            bus.mem_read         <= pick_m1 ? bus.m1_read         : bus.m0_read;
            bus.mem_write        <= pick_m1 ? bus.m1_write        : bus.m0_write;
          end
        end
        ACCESS: begin
          // Memory acted on the negedge inside this cycle; capture its data now.
          state         <= ACK;
          bus.mem_cs    <= 1'b0;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          last_grant    <= grant;
          if (grant) begin
            bus.m1_ack <= 1'b1;
            if (bus.mem_read) bus.m1_data_out <= bus.mem_data_in;
          end else begin
            bus.m0_ack <= 1'b1;
            if (bus.mem_read) bus.m0_data_out <= bus.mem_data_in;
          end
        end
        ACK: begin
          state      <= IDLE;
          bus.m0_ack <= 1'b0;
          bus.m1_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
